// File: rtl/minmax_search_pkg.sv
// minmax_pkg: shared FSM state, mode encodings and default widths for minmax_search.
package minmax_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 8;
    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/minmax_search_if.sv
// minmax_search_if: control, sample stream and result handshake of minmax_search.
interface minmax_search_if #(parameter int DATA_W = 16, parameter int CNT_W = 8);
    logic              start_i;
    logic              mode_i;
    logic [CNT_W-1:0]  len_i;
    logic              sample_valid_i;
    logic [DATA_W-1:0] sample_i;
    logic              sample_ready_o;
    logic              busy_o;
    logic              result_valid_o;
    logic [DATA_W-1:0] result_o;
    logic [CNT_W-1:0]  index_o;
    logic              result_ack_i;
    modport master (
        output start_i, mode_i, len_i, sample_valid_i, sample_i, result_ack_i,
        input  sample_ready_o, busy_o, result_valid_o, result_o, index_o
    );
    modport slave (
        input  start_i, mode_i, len_i, sample_valid_i, sample_i, result_ack_i,
        output sample_ready_o, busy_o, result_valid_o, result_o, index_o
    );
endinterface

// File: rtl/minmax_search_cmp.sv
// minmax_cmp: combinational replace decision for a candidate against the current best.
// Define MINMAX_SEARCH_ABS_EN to compare magnitudes (most negative value saturates).
module minmax_cmp
    import minmax_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic signed [DATA_W-1:0] i_cand,
    input  logic signed [DATA_W-1:0] i_best,
    input  logic                     i_mode,
    output logic                     o_replace
);
    logic signed [DATA_W-1:0] w_cand;
    logic signed [DATA_W-1:0] w_best;
`ifdef MINMAX_SEARCH_ABS_EN
    localparam logic signed [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    function automatic logic signed [DATA_W-1:0] sat_abs(input logic signed [DATA_W-1:0] x);
        return (x == MIN_NEG) ? MAX_POS : (x[DATA_W-1] ? -x : x);
    endfunction
    assign w_cand = sat_abs(i_cand);
    assign w_best = sat_abs(i_best);
`else
    assign w_cand = i_cand;
    assign w_best = i_best;
`endif
    // strict compare so ties keep the earlier index
    assign o_replace = (i_mode == MODE_MIN) ? (w_cand < w_best) : (w_cand > w_best);
endmodule

// File: rtl/minmax_search.sv
// minmax_search: streams len samples and reports the signed max/min value and its index.
// Optional MINMAX_SEARCH_ABS_EN switches the compare to magnitudes (see minmax_cmp).
module minmax_search
    import minmax_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    minmax_search_if.slave bus
);
    state_t                   r_state;
    logic                     r_mode;
    logic [CNT_W-1:0]         r_len;
    logic [CNT_W-1:0]         r_cnt;
    logic signed [DATA_W-1:0] r_best;
    logic [CNT_W-1:0]         r_index;
    logic                     r_ready;
    logic                     r_busy;
    logic                     r_valid;
    logic                     w_xfer;
    logic                     w_last;
    logic                     w_replace;

    assign w_xfer = bus.sample_valid_i & r_ready;
    // len 0 wraps to all-ones here, giving the full 2^CNT_W run
    assign w_last = (r_cnt == r_len - CNT_W'(1));

    minmax_cmp #(.DATA_W(DATA_W)) u_cmp (
        .i_cand    (bus.sample_i),
        .i_best    (r_best),
        .i_mode    (r_mode),
        .o_replace (w_replace)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_mode  <= MODE_MAX;
            r_len   <= '0;
            r_cnt   <= '0;
            r_best  <= '0;
            r_index <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start_i) begin
                    r_state <= S_RUN;
                    r_mode  <= bus.mode_i;
                    r_len   <= bus.len_i;
                    r_cnt   <= '0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b1;
                end
                S_RUN: if (w_xfer) begin
                    if (r_cnt == '0 || w_replace) begin
                        r_best  <= bus.sample_i;
                        r_index <= r_cnt;
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_ready <= 1'b0;
                        r_valid <= 1'b1;
                    end
                end
                S_DONE: if (bus.result_ack_i) begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.sample_ready_o = r_ready;
    assign bus.busy_o         = r_busy;
    assign bus.result_valid_o = r_valid;
    assign bus.result_o       = r_best;
    assign bus.index_o        = r_index;
endmodule

// File: doc/minmax_search.md
MINMAX_SEARCH -- requirements
Module: minmax_search

Interface
REQ-001 Parameter DATA_W, default 16: sample width, signed two's complement.
REQ-002 Parameter CNT_W, default 8: length/index width; maximum vector length is 2^CNT_W.
REQ-003 clk_i  input  1: single clock; all state updates on the rising edge.
REQ-004 rst_n_i  input  1: asynchronous, active-low reset.
REQ-005 start_i  input  1: begins a search when in IDLE.
REQ-006 mode_i  input  1: 0 = search maximum, 1 = search minimum; sampled with start_i.
REQ-007 len_i  input  CNT_W: vector length, sampled with start_i; 0 means 2^CNT_W.
REQ-008 sample_valid_i  input  1: sample_i is valid.
REQ-009 sample_i  input  DATA_W: current sample.
REQ-010 sample_ready_o  output  1: block accepts a sample this cycle.
REQ-011 busy_o  output  1: high in RUN and DONE.
REQ-012 result_valid_o  output  1: result_o and index_o are valid.
REQ-013 result_o  output  DATA_W: extreme sample value.
REQ-014 index_o  output  CNT_W: 0-based position of the extreme sample.
REQ-015 result_ack_i  input  1: consumer takes the result.

Function
REQ-016 FSM states: IDLE, RUN, DONE.
REQ-017 IDLE -> RUN on start_i; latch mode_i and len_i; clear the sample counter.
REQ-018 start_i outside IDLE is ignored.
REQ-019 sample_ready_o is 1 exactly in RUN; a sample transfers when sample_valid_i and sample_ready_o are both 1.
REQ-020 First transferred sample (index 0) loads the best register unconditionally.
REQ-021 Later samples replace best/index only if strictly greater (max) or strictly less (min); ties keep the earlier index.
REQ-022 Compare is a full signed compare: no wrap error at -2^(DATA_W-1) vs 2^(DATA_W-1)-1.
REQ-023 RUN -> DONE in the cycle after the transfer of sample len-1; result_valid_o rises in that same cycle (latency 1 from the last sample).
REQ-024 Cycles without sample_valid_i stall RUN with no state change.
REQ-025 DONE holds result_valid_o, result_o and index_o stable until result_ack_i; DONE -> IDLE on result_ack_i.
REQ-026 result_ack_i outside DONE is ignored.
REQ-027 start_i in the same cycle as result_ack_i is ignored; a new start requires IDLE.
REQ-028 len_i = 0 processes 2^CNT_W samples; the counter must not wrap prematurely.
REQ-029 result_o and index_o keep their last value in IDLE.

Reset
REQ-030 Asserting rst_n_i in any state, including mid-RUN, forces IDLE immediately.
REQ-031 On reset: sample_ready_o=0, busy_o=0, result_valid_o=0, result_o=0, index_o=0, counter=0, latched mode=0.
REQ-032 Reset deassertion produces no result and no sample acceptance until a new start_i.

Configuration
REQ-033 Macro MINMAX_SEARCH_ABS_EN defined: compare on |sample|. -2^(DATA_W-1) saturates to 2^(DATA_W-1)-1. result_o reports the original signed sample.
REQ-034 Macro MINMAX_SEARCH_ABS_EN undefined: compare on the signed value; no abs logic is present.

Structure
REQ-035 Shared package minmax_pkg holds the FSM state enum, the mode encodings (MODE_MAX=0, MODE_MIN=1) and the default widths.
REQ-036 Sub-module minmax_cmp takes candidate, best and mode and returns a one-bit replace decision; it is combinational and owns the signed compare and the optional abs.

Verification
REQ-037 Max with len=4, samples 3, -7, 9, 9 -> result 9, index 2 (tie keeps first), result_valid_o 1 cycle after the 4th transfer.
REQ-038 Min with len=3, samples 0x7FFF, 0x8000, 0x0001 -> result 0x8000, index 1; no overflow misorder.
REQ-039 Backpressure: max len=2 with sample_valid_i gaps of 3 cycles -> same result as the gapless run; result held 5 cycles until result_ack_i, then IDLE.
REQ-040 Reset mid-RUN after 2 of 5 samples -> all outputs 0 and IDLE; a following start with len=1, sample -5 gives result -5, index 0.
REQ-041 len=0 with DATA_W=16, CNT_W=8, ramp 0..255 in max mode -> result 255, index 255 after exactly 256 transfers.
REQ-042 With MINMAX_SEARCH_ABS_EN, max mode, len=3, samples 5, -12, 8 -> result -12, index 1.
